// File: rtl/replica_pkg.sv
// replica_pkg: shared widths and types for the replica scatter/router pair.
//   DATALEN  width of one real or imaginary component
//   REPLLEN  width of a lane number / pointer
//   REPLICA  number of replica lanes (2 .. 2**REPLLEN)
//   INDXLEN  width of the frequency index travelling with each sample
package replica_pkg;

  localparam int DATALEN = 16;
  localparam int REPLLEN = 4;
  localparam int REPLICA = 8;
  localparam int INDXLEN = 6;
  localparam int SAMPLEW = 2 * DATALEN;

  typedef struct packed {
    logic [DATALEN-1:0] re;
    logic [DATALEN-1:0] im;
  } sample_t;

  typedef logic [INDXLEN-1:0] index_t;
  typedef logic [REPLLEN-1:0] lane_t;

  // One extra bit so REPLICA == 2**REPLLEN still compares correctly.
  function automatic logic lane_legal(input lane_t l);
    return {1'b0, l} < (REPLLEN + 1)'(REPLICA);
  endfunction

  function automatic lane_t lane_next(input lane_t l);
    return (l == lane_t'(REPLICA - 1)) ? '0 : l + lane_t'(1);
  endfunction

endpackage

// File: rtl/replica_slot.sv
// replica_slot: one-entry registered output slot for a single replica lane.
//   clk, rstn   clock, async active-low reset
//   clr         synchronous clear of the valid flag
//   load        write in_data/in_index this edge (only asserted when load_ok)
//   out_ready   consumer ready for this lane
//   in_data     sample to store
//   in_index    frequency index to store
//   out_valid   slot full
//   out_data    stored sample
//   out_index   stored index
//   load_ok     slot can take a beat this cycle (empty, or draining now)
module replica_slot
  import replica_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    clr,
  input  logic    load,
  input  logic    out_ready,
  input  sample_t in_data,
  input  index_t  in_index,
  output logic    out_valid,
  output sample_t out_data,
  output index_t  out_index,
  output logic    load_ok
);

  // Pass-through drain: a full slot being read this cycle can be refilled.
  assign load_ok = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (clr) begin
      // Payload is left stale; only the valid flag matters after a clear.
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_index <= in_index;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/replica_scatter.sv
// replica_scatter: distributes a stream of complex samples over REPLICA lanes.
//   clk, rstn   clock, async active-low reset
//   clr         synchronous clear: empties all slots, rr_ptr -> 0
//   mode        0 = directed (in_dest), 1 = round-robin (rr_ptr)
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid & in_ready
//   in_data     sample {re, im}
//   in_index    frequency index
//   in_dest     destination lane in directed mode
//   out_valid   per-lane slot full
//   out_ready   per-lane consumer ready
//   out_data    per-lane sample
//   out_index   per-lane index
//   rr_ptr      next round-robin lane
//   drop_err    one-cycle pulse after a directed beat to a nonexistent lane
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Valid, once high, holds with stable payload until that edge; ready may
// depend combinationally on the other side's signals. in_ready here depends on
// out_ready, mode, in_dest and rr_ptr, but never on in_valid.
module replica_scatter
  import replica_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  sample_t            in_data,
  input  index_t             in_index,
  input  lane_t              in_dest,
  output logic [REPLICA-1:0] out_valid,
  input  logic [REPLICA-1:0] out_ready,
  output sample_t            out_data  [REPLICA],
  output index_t             out_index [REPLICA],
  output lane_t              rr_ptr,
  output logic               drop_err
);

  lane_t              tgt;
  logic               tgt_ok;
  logic               sel_ok;
  logic               accept;
  logic [REPLICA-1:0] load_ok;
  logic [REPLICA-1:0] load;

  always_comb begin
    tgt    = mode ? rr_ptr : in_dest;
    tgt_ok = lane_legal(tgt);
    sel_ok = 1'b0;
    for (int k = 0; k < REPLICA; k++) begin
      if (tgt == lane_t'(k)) sel_ok = load_ok[k];
    end
    // An illegal lane is always accepted so the beat can be discarded.
    in_ready = ~clr & (~tgt_ok | sel_ok);
    accept   = in_valid & in_ready;
  end

  for (genvar k = 0; k < REPLICA; k++) begin : g_lane
    assign load[k] = accept & tgt_ok & (tgt == lane_t'(k));

    replica_slot u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .load      (load[k]),
      .out_ready (out_ready[k]),
      .in_data   (in_data),
      .in_index  (in_index),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k]),
      .out_index (out_index[k]),
      .load_ok   (load_ok[k])
    );
  end

  // rr_ptr only moves on an accepted round-robin beat, so a full lane stalls
  // the rotation instead of being skipped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr   <= '0;
      drop_err <= 1'b0;
    end else if (clr) begin
      rr_ptr   <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept & ~tgt_ok;
      if (accept && mode) rr_ptr <= lane_next(rr_ptr);
    end
  end

endmodule

// File: tb/tb_replica_scatter.sv
// tb_replica_scatter: directed + randomized bench for replica_scatter.
// Reference model: each lane is a queue of {data,index} words (at most one
// deep); the round-robin pointer is a plain integer modulo REPLICA.
module tb_replica_scatter;
  import replica_pkg::*;

  localparam int W = SAMPLEW + INDXLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic               clr;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [SAMPLEW-1:0] in_data;
  index_t             in_index;
  lane_t              in_dest;
  logic [REPLICA-1:0] out_valid;
  logic [REPLICA-1:0] out_ready;
  sample_t            out_data  [REPLICA];
  index_t             out_index [REPLICA];
  lane_t              rr_ptr;
  logic               drop_err;

  replica_scatter dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_index  (in_index),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .rr_ptr    (rr_ptr),
    .drop_err  (drop_err)
  );

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [W-1:0] exp_q [REPLICA][$];
  int         rr_m;
  bit         drop_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < REPLICA; k++) exp_q[k].delete();
    rr_m   = 0;
    drop_m = 1'b0;
  endtask

  task automatic check_outputs();
    logic [REPLICA-1:0] ev;
    logic [W-1:0]       e;
    ev = '0;
    for (int k = 0; k < REPLICA; k++) ev[k] = (exp_q[k].size() != 0);
    check("out_valid", 64'(out_valid), 64'(ev));
    for (int k = 0; k < REPLICA; k++) begin
      if (ev[k]) begin
        e = exp_q[k][0];
        check($sformatf("out_data[%0d]", k), 64'(out_data[k]), 64'(e[W-1:INDXLEN]));
        check($sformatf("out_index[%0d]", k), 64'(out_index[k]), 64'(e[INDXLEN-1:0]));
      end
    end
    check("rr_ptr", 64'(rr_ptr), 64'(rr_m));
    check("drop_err", 64'(drop_err), 64'(drop_m));
  endtask

  // ---------------- driver ----------------
  // Inputs are already set by the caller; checks in_ready, clocks once,
  // advances the model, then checks registered outputs.
  task automatic step();
    int tgt;
    bit er;
    bit acc;
    #1;
    tgt = mode ? rr_m : int'(in_dest);
    er  = !clr && (tgt >= REPLICA || exp_q[tgt].size() == 0 || out_ready[tgt]);
    check("in_ready", 64'(in_ready), 64'(er));
    acc = in_valid && er;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      for (int k = 0; k < REPLICA; k++)
        if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
      drop_m = 1'b0;
      if (acc) begin
        if (tgt < REPLICA) exp_q[tgt].push_back({in_data, in_index});
        else drop_m = 1'b1;
        if (mode) rr_m = (rr_m + 1) % REPLICA;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic beat(input logic [REPLICA-1:0] d_or_unused, input int idx);
    in_valid = 1'b1;
    in_index = index_t'(idx);
    in_data  = SAMPLEW'($urandom);
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rstn = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = '0; in_index = '0; in_dest = '0; out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    for (int k = 0; k < REPLICA; k++) begin
      check("reset_out_data", 64'(out_data[k]), 64'(0));
      check("reset_out_index", 64'(out_index[k]), 64'(0));
    end
    @(negedge clk) rstn = 1'b1;

    // Directed fill of every lane with consumers stalled.
    mode = 1'b0;
    out_ready = '0;
    for (int d = 0; d < REPLICA; d++) begin
      in_dest = lane_t'(d);
      beat('0, d);
    end
    check("fill_all_valid", 64'(out_valid), 64'(8'hFF));
    in_dest = lane_t'(3);
    beat('0, 8);
    check("ninth_blocked", 64'(in_ready), 64'(0));
    out_ready = 8'b0000_1000;
    step();
    check("ninth_lane3_index", 64'(out_index[3]), 64'(8));
    check("ninth_still_full", 64'(out_valid), 64'(8'hFF));
    in_valid = 1'b0;
    out_ready = '1;
    step();
    step();

    // Round-robin streaming with all consumers ready.
    mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("rr_seq", 64'(rr_ptr), 64'(i % REPLICA));
      beat('0, i);
    end
    check("rr_lane7_index", 64'(out_index[7]), 64'(15));

    // Backpressure on lane 2: the rotation must stall there.
    out_ready = 8'hFB;
    for (int i = 0; i < 10; i++) beat('0, 20 + i);
    check("stall_ptr", 64'(rr_ptr), 64'(2));
    beat('0, 40);
    beat('0, 40);
    check("stall_ready", 64'(in_ready), 64'(0));
    check("stall_ptr_hold", 64'(rr_ptr), 64'(2));
    out_ready = '1;
    step();
    check("lane2_kept_valid", 64'(out_valid[2]), 64'(1));
    check("lane2_new_index", 64'(out_index[2]), 64'(40));
    check("ptr_after_stall", 64'(rr_ptr), 64'(3));
    in_valid = 1'b0;
    step();

    // Illegal directed destination with some slots full.
    out_ready = '0;
    beat('0, 50);
    beat('0, 51);
    mode = 1'b0;
    in_dest = lane_t'(9);
    beat('0, 52);
    check("drop_pulse", 64'(drop_err), 64'(1));
    check("drop_no_slot_change", 64'(out_valid), 64'(8'h18));
    in_dest = lane_t'(15);
    beat('0, 53);
    check("drop_pulse_15", 64'(drop_err), 64'(1));
    in_valid = 1'b0;
    step();
    check("drop_one_cycle", 64'(drop_err), 64'(0));

    // Synchronous clear with five slots full and rr_ptr = 5.
    clr = 1'b1;
    step();
    clr = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < 5; i++) beat('0, i);
    check("pre_clr_ptr", 64'(rr_ptr), 64'(5));
    check("pre_clr_valid", 64'(out_valid), 64'(8'h1F));
    clr = 1'b1;
    step();
    check("clr_valid", 64'(out_valid), 64'(0));
    check("clr_ptr", 64'(rr_ptr), 64'(0));
    clr = 1'b0;

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) beat('0, 10 + i);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'(0));
    check("async_ptr", 64'(rr_ptr), 64'(0));
    check("async_data0", 64'(out_data[0]), 64'(0));
    model_reset();
    @(negedge clk) rstn = 1'b1;

    // Randomized traffic against the model.
    repeat (400) begin
      clr       = ($urandom_range(0, 31) == 0);
      mode      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_dest   = lane_t'($urandom_range(0, 9));
      in_index  = index_t'($urandom_range(0, 63));
      in_data   = SAMPLEW'($urandom);
      out_ready = REPLICA'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
